diffeq_solver_stream: RTL and testbench
=======================================

// Module: diffeq_solver_stream
// PURPOSE
//  Parametrised, handshaked successor to the team's single-channel diffeq iteration engine.
//  Integrates y'' + 3xy' + 3y = 0 by forward Euler from (x,y,u) until x >= a.
//  Supports configurable width, fixed-point fraction bits and an iteration cap.
//  Uses valid/ready handshakes on both sides so it can sit between stream FIFOs in the datapath.
// PARAMETERS
//  W        32     datapath width of x, y, u, a, dx (bits)
//  FRAC     0      fraction bits, Q(W-FRAC).FRAC; 0 = pure integer
//  ITER_W   16     iteration counter width
//  MAX_ITER 65535  iteration cap, 1..2**ITER_W-1; reaching it forces termination
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-low reset
//  in_valid     in   1       job offered
//  in_ready     out  1       solver idle, can accept a job
//  x_in,y_in,u_in in W       initial state
//  a_in         in   W       x limit
//  dx_in        in   W       step
//  out_valid    out  1       result held
//  out_ready    in   1       consumer accepts result
//  x_out,y_out,u_out out W   final state
//  iter_out     out  ITER_W  iterations performed
//  timeout_out  out  1       1 = stopped by MAX_ITER, not by x >= a
// BEHAVIOUR
//  Reset: clk and reset fixed as stated; reset low asynchronously forces state IDLE.
//   All internal registers and all outputs clear to 0; in_ready is 1 while in IDLE.
//  Reset mid-operation: job discarded, no output produced; first accept possible one edge after reset release.
//  FSM states IDLE, ITER, DONE (encoding in package). in_ready = (state==IDLE).
//   IDLE: on in_valid at an edge, load x,y,u,a,dx; clear iter cnt; go to ITER.
//   ITER: each edge, evaluate the exit test on the current registers.
//    Exit test: x >= a (unsigned compare) OR cnt == MAX_ITER.
//    If exit: register x,y,u,cnt to the outputs; timeout_out = (x < a); go to DONE.
//    Otherwise: apply one step and cnt += 1.
//   DONE: out_valid=1; outputs stable until out_ready=1 at an edge, then go to IDLE (out_valid=0).
//   No new job is accepted in the same cycle as result hand-off; one idle cycle minimum.
//  Latency: N iterations -> out_valid rises N+1 edges after the accept edge.
//  Step (all from old values, simultaneous update, arithmetic mod 2**W):
//   t  = (u*dx) >> FRAC
//   u' = u - ((t*3*x) >> FRAC) - ((dx*3*y) >> FRAC)
//   y' = y + t
//   x' = x + dx
//   Products are formed full-width 2W and logically shifted, then truncated to the low W bits.
//   u wraps in two's complement; no saturation.
//  Boundary cases:
//   x_in >= a_in: zero iterations, outputs = inputs, iter 0.
//   dx = 0 or x wraps: bounded by MAX_ITER, timeout_out = 1.
//   in_valid while busy: ignored, because in_ready = 0.
// STRUCTURE
//  diffeq_pkg: state enum (IDLE/ITER/DONE), localparam COEF = 3.
//  Sub-module diffeq_step: combinational datapath computing (x',y',u') from (x,y,u,dx).
//   Parameters W and FRAC.
//  Top level: FSM, iteration counter, operand and result registers.
// TESTING
//  1 Basic run: W=32, FRAC=0; x=0,y=0,u=1,a=2,dx=1.
//    -> x=2, y=2, u=0xFFFFFFFB, iter=2, timeout=0.
//    -> out_valid 3 edges after accept.
//  2 Immediate exit: x=5, a=5 -> outputs equal inputs, iter=0.
//    -> out_valid 1 edge after accept.
//  3 Iteration cap: MAX_ITER=4, dx=0, x=0, a=1 -> iter=4, timeout=1, x=0.
//  4 Backpressure: hold out_ready=0 for 10 cycles -> outputs and out_valid stable.
//    -> in_ready=0 and a second in_valid is ignored.
//    -> the second job is accepted only after hand-off.
//  5 Reset mid-op: assert reset low during ITER of test 1.
//    -> all outputs 0 immediately, with no clk edge needed; in_ready=1 after release.
//    -> a rerun of test 1 gives identical results.
//  6 Fixed point: FRAC=8; x=0, y=0, u=0x100 (1.0), dx=0x80 (0.5), a=0x100.
//    -> iter=2, x=0x100, y=0x100, u=0xFFFFFF80 (-0.5).

Source files
------------

// File: rtl/diffeq_pkg.sv
// Shared types and constants for the streaming diffeq solver.
// The state encoding lives here so the top and any debug tooling agree.
package diffeq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Coefficient of both the x*y' and y terms in y'' + 3xy' + 3y = 0
  localparam int COEF = 3;

endpackage

// File: rtl/diffeq_step.sv
// One forward-Euler step of the diffeq system, purely combinational.
// All outputs derive from the old (x,y,u) so the caller can update them together.
module diffeq_step
  import diffeq_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = 0
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] u,
  input  logic [W-1:0] dx,
  output logic [W-1:0] x_next,
  output logic [W-1:0] y_next,
  output logic [W-1:0] u_next
);

  localparam logic [2*W-1:0] COEF_WIDE = (2*W)'(COEF);

  logic [2*W-1:0] u_wide, dx_wide, x_wide, y_wide, t_wide;
  logic [W-1:0]   t;
  logic [W-1:0]   tx_term, dy_term;

  assign u_wide  = {{W{1'b0}}, u};
  assign dx_wide = {{W{1'b0}}, dx};
  assign x_wide  = {{W{1'b0}}, x};
  assign y_wide  = {{W{1'b0}}, y};

  // Products are unsigned 2W wide, shifted logically, then truncated to W
  assign t       = W'((u_wide * dx_wide) >> FRAC);
  assign t_wide  = {{W{1'b0}}, t};
  assign tx_term = W'((t_wide * COEF_WIDE * x_wide) >> FRAC);
  assign dy_term = W'((dx_wide * COEF_WIDE * y_wide) >> FRAC);

  assign x_next = x + dx;
  assign y_next = y + t;
  assign u_next = u - tx_term - dy_term;

endmodule

// File: rtl/diffeq_solver_stream.sv
// Handshaked diffeq iteration engine: accepts (x,y,u,a,dx), steps until x >= a
// or the iteration cap is hit, then holds the result until the consumer takes it.
module diffeq_solver_stream
  import diffeq_pkg::*;
#(
  parameter int W        = 32,
  parameter int FRAC     = 0,
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      x_in,
  input  logic [W-1:0]      y_in,
  input  logic [W-1:0]      u_in,
  input  logic [W-1:0]      a_in,
  input  logic [W-1:0]      dx_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      x_out,
  output logic [W-1:0]      y_out,
  output logic [W-1:0]      u_out,
  output logic [ITER_W-1:0] iter_out,
  output logic              timeout_out
);

  localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

  state_t              state_reg, state_next;
  logic [W-1:0]        x_reg, y_reg, u_reg, a_reg, dx_reg;
  logic [ITER_W-1:0]   cnt_reg;
  logic [W-1:0]        x_next, y_next, u_next;
  logic                exit_hit;
  logic                load, step, finish;

  diffeq_step #(
    .W    (W),
    .FRAC (FRAC)
  ) u_step (
    .x      (x_reg),
    .y      (y_reg),
    .u      (u_reg),
    .dx     (dx_reg),
    .x_next (x_next),
    .y_next (y_next),
    .u_next (u_next)
  );

  assign exit_hit  = (x_reg >= a_reg) || (cnt_reg == MAX_CNT);
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          state_next = ITER;
        end
      end
      ITER: begin
        if (exit_hit) begin
          finish     = 1'b1;
          state_next = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_reg   <= '0;
      y_reg   <= '0;
      u_reg   <= '0;
      a_reg   <= '0;
      dx_reg  <= '0;
      cnt_reg <= '0;
    end else if (load) begin
      x_reg   <= x_in;
      y_reg   <= y_in;
      u_reg   <= u_in;
      a_reg   <= a_in;
      dx_reg  <= dx_in;
      cnt_reg <= '0;
    end else if (step) begin
      x_reg   <= x_next;
      y_reg   <= y_next;
      u_reg   <= u_next;
      cnt_reg <= cnt_reg + ITER_W'(1);
    end
  end

  // Result registers only change on the exit edge, so they stay put through backpressure
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_out       <= '0;
      y_out       <= '0;
      u_out       <= '0;
      iter_out    <= '0;
      timeout_out <= 1'b0;
    end else if (finish) begin
      x_out       <= x_reg;
      y_out       <= y_reg;
      u_out       <= u_reg;
      iter_out    <= cnt_reg;
      timeout_out <= (x_reg < a_reg);
    end
  end

endmodule

// File: tb/tb_diffeq_solver_stream.sv
// Directed bench for diffeq_solver_stream: default, capped and fixed-point instances.
module tb_diffeq_solver_stream;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] x_i = '0, y_i = '0, u_i = '0, a_i = '0, dx_i = '0;
  logic        iv [3];
  logic        ordy [3];
  logic        ir [3];
  logic        ov [3];
  logic [31:0] x_o [3];
  logic [31:0] y_o [3];
  logic [31:0] u_o [3];
  logic [15:0] it_o [3];
  logic        to_o [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  diffeq_solver_stream #(.W(32), .FRAC(0), .ITER_W(16), .MAX_ITER(65535)) dut (
    .clk(clk), .reset(reset_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .x_in(x_i), .y_in(y_i), .u_in(u_i), .a_in(a_i), .dx_in(dx_i),
    .out_valid(ov[0]), .out_ready(ordy[0]), .x_out(x_o[0]), .y_out(y_o[0]),
    .u_out(u_o[0]), .iter_out(it_o[0]), .timeout_out(to_o[0]));

  diffeq_solver_stream #(.W(32), .FRAC(0), .ITER_W(16), .MAX_ITER(4)) dut_cap (
    .clk(clk), .reset(reset_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .x_in(x_i), .y_in(y_i), .u_in(u_i), .a_in(a_i), .dx_in(dx_i),
    .out_valid(ov[1]), .out_ready(ordy[1]), .x_out(x_o[1]), .y_out(y_o[1]),
    .u_out(u_o[1]), .iter_out(it_o[1]), .timeout_out(to_o[1]));

  diffeq_solver_stream #(.W(32), .FRAC(8), .ITER_W(16), .MAX_ITER(65535)) dut_fx (
    .clk(clk), .reset(reset_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .x_in(x_i), .y_in(y_i), .u_in(u_i), .a_in(a_i), .dx_in(dx_i),
    .out_valid(ov[2]), .out_ready(ordy[2]), .x_out(x_o[2]), .y_out(y_o[2]),
    .u_out(u_o[2]), .iter_out(it_o[2]), .timeout_out(to_o[2]));

  task automatic start_job(input int sel, input logic [31:0] x, y, u, a, dx);
    @(negedge clk);
    x_i = x; y_i = y; u_i = u; a_i = a; dx_i = dx;
    iv[sel] = 1'b1;
    @(posedge clk);
    #1;
    iv[sel] = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int budget, output int edges);
    edges = 0;
    while (ov[sel] !== 1'b1 && edges < budget) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic handoff(input int sel);
    ordy[sel] = 1'b1;
    @(posedge clk);
    #1;
    ordy[sel] = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ov[0] !== 1'b0 || x_o[0] !== 32'd0 || y_o[0] !== 32'd0 || u_o[0] !== 32'd0 ||
        it_o[0] !== 16'd0 || to_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got ov=%b x=%h y=%h u=%h it=%0d to=%b exp all 0",
               ov[0], x_o[0], y_o[0], u_o[0], it_o[0], to_o[0]);
    end
    checks++;
    if (ir[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", ir[0]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    $display("reset released");
  endtask

  task automatic run_basic(input string tag);
    int edges;
    start_job(0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd1);
    wait_done(0, 50, edges);
    checks++;
    if (edges !== 3) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=3", tag, edges);
    end
    checks++;
    if (x_o[0] !== 32'd2 || y_o[0] !== 32'd2 || u_o[0] !== 32'hFFFF_FFFB) begin
      failures++;
      $display("FAIL %s_state got x=%h y=%h u=%h exp x=2 y=2 u=fffffffb", tag, x_o[0], y_o[0], u_o[0]);
    end
    checks++;
    if (it_o[0] !== 16'd2 || to_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL %s_iter got it=%0d to=%b exp it=2 to=0", tag, it_o[0], to_o[0]);
    end
    $display("%s: x=%h y=%h u=%h iter=%0d timeout=%b edges=%0d", tag, x_o[0], y_o[0], u_o[0], it_o[0], to_o[0], edges);
    handoff(0);
  endtask

  task automatic test_basic;
    run_basic("basic");
  endtask

  task automatic test_immediate_exit;
    int edges;
    start_job(0, 32'd5, 32'd3, 32'd4, 32'd5, 32'd1);
    wait_done(0, 50, edges);
    checks++;
    if (edges !== 1) begin
      failures++;
      $display("FAIL immediate_latency got=%0d exp=1", edges);
    end
    checks++;
    if (x_o[0] !== 32'd5 || y_o[0] !== 32'd3 || u_o[0] !== 32'd4 || it_o[0] !== 16'd0 || to_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL immediate_result got x=%h y=%h u=%h it=%0d to=%b exp 5 3 4 0 0",
               x_o[0], y_o[0], u_o[0], it_o[0], to_o[0]);
    end
    $display("immediate: x=%h y=%h u=%h iter=%0d edges=%0d", x_o[0], y_o[0], u_o[0], it_o[0], edges);
    handoff(0);
  endtask

  task automatic test_iter_cap;
    int edges;
    start_job(1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0);
    wait_done(1, 50, edges);
    checks++;
    if (edges !== 5) begin
      failures++;
      $display("FAIL cap_latency got=%0d exp=5", edges);
    end
    checks++;
    if (it_o[1] !== 16'd4 || to_o[1] !== 1'b1 || x_o[1] !== 32'd0) begin
      failures++;
      $display("FAIL cap_result got it=%0d to=%b x=%h exp it=4 to=1 x=0", it_o[1], to_o[1], x_o[1]);
    end
    $display("cap: x=%h iter=%0d timeout=%b edges=%0d", x_o[1], it_o[1], to_o[1], edges);
    handoff(1);
  endtask

  task automatic test_backpressure;
    int edges;
    int bad;
    start_job(0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd1);
    wait_done(0, 50, edges);
    @(negedge clk);
    x_i = 32'd5; y_i = 32'd7; u_i = 32'd9; a_i = 32'd5; dx_i = 32'd1;
    iv[0] = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || x_o[0] !== 32'd2 || y_o[0] !== 32'd2 ||
          u_o[0] !== 32'hFFFF_FFFB || it_o[0] !== 16'd2) begin
        failures++;
        bad++;
        $display("FAIL bp_hold cycle=%0d got ov=%b ir=%b x=%h y=%h u=%h it=%0d exp ov=1 ir=0 x=2 y=2 u=fffffffb it=2",
                 i, ov[0], ir[0], x_o[0], y_o[0], u_o[0], it_o[0]);
      end
    end
    $display("backpressure: held 10 cycles, bad=%0d", bad);
    handoff(0);
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      failures++;
      $display("FAIL bp_handoff got ov=%b ir=%b exp ov=0 ir=1", ov[0], ir[0]);
    end
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    checks++;
    if (ir[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_second_accept got ir=%b exp=0", ir[0]);
    end
    wait_done(0, 50, edges);
    checks++;
    if (edges !== 1 || x_o[0] !== 32'd5 || y_o[0] !== 32'd7 || u_o[0] !== 32'd9 || it_o[0] !== 16'd0) begin
      failures++;
      $display("FAIL bp_second_result got edges=%0d x=%h y=%h u=%h it=%0d exp 1 5 7 9 0",
               edges, x_o[0], y_o[0], u_o[0], it_o[0]);
    end
    $display("backpressure second job: x=%h y=%h u=%h iter=%0d", x_o[0], y_o[0], u_o[0], it_o[0]);
    handoff(0);
  endtask

  task automatic test_reset_midop;
    start_job(0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || x_o[0] !== 32'd0 || y_o[0] !== 32'd0 || u_o[0] !== 32'd0 ||
        it_o[0] !== 16'd0 || to_o[0] !== 1'b0 || ir[0] !== 1'b1) begin
      failures++;
      $display("FAIL midop_async_clear got ov=%b x=%h y=%h u=%h it=%0d to=%b ir=%b exp zeros, ir=1",
               ov[0], x_o[0], y_o[0], u_o[0], it_o[0], to_o[0], ir[0]);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
      failures++;
      $display("FAIL midop_release got ir=%b ov=%b exp ir=1 ov=0", ir[0], ov[0]);
    end
    $display("reset mid-op: cleared, ir=%b", ir[0]);
    run_basic("rerun");
  endtask

  task automatic test_fixed_point;
    int edges;
    start_job(2, 32'd0, 32'd0, 32'h100, 32'h100, 32'h80);
    wait_done(2, 50, edges);
    checks++;
    if (edges !== 3 || it_o[2] !== 16'd2 || to_o[2] !== 1'b0) begin
      failures++;
      $display("FAIL fx_iter got edges=%0d it=%0d to=%b exp 3 2 0", edges, it_o[2], to_o[2]);
    end
    checks++;
    if (x_o[2] !== 32'h100 || y_o[2] !== 32'h100 || u_o[2] !== 32'hFFFF_FF80) begin
      failures++;
      $display("FAIL fx_state got x=%h y=%h u=%h exp x=100 y=100 u=ffffff80", x_o[2], y_o[2], u_o[2]);
    end
    $display("fixed point: x=%h y=%h u=%h iter=%0d", x_o[2], y_o[2], u_o[2], it_o[2]);
    handoff(2);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_immediate_exit();
    test_iter_cap();
    test_backpressure();
    test_reset_midop();
    test_fixed_point();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
